// File: rtl/c2c_bus_arbiter_pkg.sv
// Shared types and bus widths for the c2c memory-port arbiter.
package c2c_bus_arbiter_pkg;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 32;
  localparam int SEL_W  = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN_I,
    ARB_OWN_D
  } arb_state_t;

  function automatic logic is_req(input logic re, input logic we);
    return re | we;
  endfunction

endpackage

// File: rtl/c2c_bus_arbiter_if.sv
// c2c_data memory-style port: requester (master) drives addr/data_w/sel/re/we and holds them until ack.
interface c2c_data;
  import c2c_bus_arbiter_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   data_w;
  logic [XLEN-1:0]   data_r;
  logic [SEL_W-1:0]  sel;
  logic              re;
  logic              we;
  logic              ack;

  modport master (
    output addr, data_w, sel, re, we,
    input  data_r, ack
  );

  modport slave (
    input  addr, data_w, sel, re, we,
    output data_r, ack
  );

endinterface

// File: rtl/c2c_bus_arbiter.sv
// Grants the shared memory port to fetch or LSU; 1-cycle arbitration, zero-gap handoff on ack.
// A requester without grant simply waits (no ack); a watchdog force-releases a stuck owner.
module c2c_bus_arbiter
  import c2c_bus_arbiter_pkg::*;
#(
  parameter logic DATA_PRIO = 1'b1,
  parameter int   TIMEOUT   = 256
) (
  input  logic    clk,
  input  logic    rst,
  c2c_data.slave  i_bus,
  c2c_data.slave  d_bus,
  c2c_data.master mem_bus,
  output logic    grant_i,
  output logic    grant_d,
  output logic    timeout
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  arb_state_t      state;
  logic            last_d;
  logic [WD_W-1:0] wd_cnt;

  logic req_i;
  logic req_d;
  logic own_d;
  logic owning;
  logic own_req;
  logic other_req;
  logic pick_d;
  logic wd_hit;

  assign req_i     = is_req(i_bus.re, i_bus.we);
  assign req_d     = is_req(d_bus.re, d_bus.we);
  assign own_d     = (state == ARB_OWN_D);
  assign owning    = (state == ARB_OWN_I) || own_d;
  assign own_req   = own_d ? req_d : req_i;
  assign other_req = own_d ? req_i : req_d;

  // On a tie, round-robin mode hands the port to whoever was not served last.
  assign pick_d = req_d && (!req_i || DATA_PRIO || !last_d);

  // An owner that already dropped its request is an abort, never a timeout.
  assign wd_hit = (TIMEOUT != 0) && owning && own_req && !mem_bus.ack
                  && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      grant_i <= 1'b0;
      grant_d <= 1'b0;
      last_d  <= 1'b0;
      wd_cnt  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          wd_cnt <= '0;
          if (pick_d) begin
            state   <= ARB_OWN_D;
            grant_i <= 1'b0;
            grant_d <= 1'b1;
          end else if (req_i) begin
            state   <= ARB_OWN_I;
            grant_i <= 1'b1;
            grant_d <= 1'b0;
          end
        end
        ARB_OWN_I, ARB_OWN_D: begin
          if (mem_bus.ack || wd_hit) begin
            last_d <= own_d;
            wd_cnt <= '0;
            if (mem_bus.ack && other_req) begin
              state   <= own_d ? ARB_OWN_I : ARB_OWN_D;
              grant_i <= own_d;
              grant_d <= !own_d;
            end else begin
              state   <= ARB_IDLE;
              grant_i <= 1'b0;
              grant_d <= 1'b0;
            end
          end else if (!own_req) begin
            state   <= ARB_IDLE;
            grant_i <= 1'b0;
            grant_d <= 1'b0;
            wd_cnt  <= '0;
          end else if (TIMEOUT != 0) begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: begin
          state   <= ARB_IDLE;
          grant_i <= 1'b0;
          grant_d <= 1'b0;
          wd_cnt  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    mem_bus.addr   = '0;
    mem_bus.data_w = '0;
    mem_bus.sel    = '0;
    mem_bus.re     = 1'b0;
    mem_bus.we     = 1'b0;
    i_bus.ack      = 1'b0;
    d_bus.ack      = 1'b0;
    i_bus.data_r   = mem_bus.data_r;
    d_bus.data_r   = mem_bus.data_r;
    timeout        = 1'b0;
    if (!rst && owning) begin
      if (own_d) begin
        mem_bus.addr   = d_bus.addr;
        mem_bus.data_w = d_bus.data_w;
        mem_bus.sel    = d_bus.sel;
        mem_bus.re     = d_bus.re;
        mem_bus.we     = d_bus.we;
        d_bus.ack      = mem_bus.ack | wd_hit;
      end else begin
        mem_bus.addr   = i_bus.addr;
        mem_bus.data_w = i_bus.data_w;
        mem_bus.sel    = i_bus.sel;
        mem_bus.re     = i_bus.re;
        mem_bus.we     = i_bus.we;
        i_bus.ack      = mem_bus.ack | wd_hit;
      end
      // Forced release must not leave a half-issued access on the memory side.
      if (wd_hit) begin
        mem_bus.re = 1'b0;
        mem_bus.we = 1'b0;
        timeout    = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_c2c_bus_arbiter.sv
// Directed bench: DUT a is data-priority, DUT b round-robin; both see identical requester stimulus.
module tb_c2c_bus_arbiter;
  import c2c_bus_arbiter_pkg::*;

  logic clk;
  logic rst;
  logic              i_re;
  logic [ADDR_W-1:0] i_addr;
  logic              d_re;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [SEL_W-1:0]  d_sel;
  logic [XLEN-1:0]   d_wdat;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdat;

  logic gi_a, gd_a, to_a;
  logic gi_b, gd_b, to_b;

  int checks;
  int failures;

  c2c_data ia ();
  c2c_data da ();
  c2c_data ma ();
  c2c_data ib ();
  c2c_data db ();
  c2c_data mb ();

  assign ia.re = i_re;    assign ia.we = 1'b0;   assign ia.addr = i_addr;
  assign ia.sel = 8'hFF;  assign ia.data_w = '0;
  assign ib.re = i_re;    assign ib.we = 1'b0;   assign ib.addr = i_addr;
  assign ib.sel = 8'hFF;  assign ib.data_w = '0;
  assign da.re = d_re;    assign da.we = d_we;   assign da.addr = d_addr;
  assign da.sel = d_sel;  assign da.data_w = d_wdat;
  assign db.re = d_re;    assign db.we = d_we;   assign db.addr = d_addr;
  assign db.sel = d_sel;  assign db.data_w = d_wdat;
  assign ma.ack = mem_ack; assign ma.data_r = mem_rdat;
  assign mb.ack = mem_ack; assign mb.data_r = mem_rdat;

  c2c_bus_arbiter #(.DATA_PRIO(1'b1), .TIMEOUT(4)) u_dut_a (
    .clk(clk), .rst(rst), .i_bus(ia), .d_bus(da), .mem_bus(ma),
    .grant_i(gi_a), .grant_d(gd_a), .timeout(to_a)
  );

  c2c_bus_arbiter #(.DATA_PRIO(1'b0), .TIMEOUT(4)) u_dut_b (
    .clk(clk), .rst(rst), .i_bus(ib), .d_bus(db), .mem_bus(mb),
    .grant_i(gi_b), .grant_d(gd_b), .timeout(to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; i_re = 1'b1; i_addr = '0;
    d_re = 1'b0; d_we = 1'b1; d_addr = '0; d_sel = '0; d_wdat = '0;
    mem_ack = 1'b0; mem_rdat = '0;

    // 1: reset with both requests high
    for (int c = 0; c < 2; c++) begin
      step(); #1;
      chk("rst_grant_i", gi_a, 0);
      chk("rst_grant_d", gd_a, 0);
      chk("rst_mem_re", ma.re, 0);
      chk("rst_mem_we", ma.we, 0);
      chk("rst_acks", {ia.ack, da.ack}, 0);
    end
    rst = 1'b0; i_re = 1'b0; d_we = 1'b0;
    step(); #1;
    chk("post_rst_idle", {gi_a, gd_a}, 0);

    // 2: lone fetch, ack in the 4th owned cycle (wd_cnt==TIMEOUT-1 but acked)
    i_re = 1'b1; i_addr = 32'h1000; #1;
    chk("fetch_latency_re", ma.re, 0);
    step(); #1;
    chk("fetch_grant", {gi_a, gd_a}, 2'b10);
    chk("fetch_addr", ma.addr, 32'h1000);
    chk("fetch_re", ma.re, 1);
    step(); #1;
    chk("fetch_wait_ack", ia.ack, 0);
    step(); step();
    mem_ack = 1'b1; mem_rdat = 64'h0000_ABCD; #1;
    chk("fetch_ack", ia.ack, 1);
    chk("fetch_rdata", ia.data_r, 64'h0000_ABCD);
    chk("fetch_no_timeout", to_a, 0);
    chk("fetch_d_ack", da.ack, 0);
    step(); i_re = 1'b0; mem_ack = 1'b0; #1;
    chk("fetch_idle", {gi_a, gd_a}, 0);

    // 3: tie under data priority, zero-gap handoff to fetch
    d_we = 1'b1; d_addr = 32'h2000; d_sel = 8'h0F; d_wdat = 64'h55;
    i_re = 1'b1; i_addr = 32'h1004;
    step(); #1;
    chk("tie_grant_d", {gi_a, gd_a}, 2'b01);
    chk("tie_mem_addr", ma.addr, 32'h2000);
    chk("tie_mem_sel", ma.sel, 8'h0F);
    chk("tie_mem_we_re", {ma.we, ma.re}, 2'b10);
    chk("tie_mem_wdat", ma.data_w, 64'h55);
    mem_ack = 1'b1; #1;
    chk("tie_d_ack", {ia.ack, da.ack}, 2'b01);
    step(); d_we = 1'b0; mem_ack = 1'b0; #1;
    chk("handoff_grant_i", {gi_a, gd_a}, 2'b10);
    chk("handoff_addr", ma.addr, 32'h1004);
    mem_ack = 1'b1; #1;
    chk("handoff_i_ack", {ia.ack, da.ack}, 2'b10);
    step(); i_re = 1'b0; mem_ack = 1'b0; #1;
    chk("handoff_idle", {gi_a, gd_a}, 0);

    // 4: serve D alone, then tie: round-robin picks I, priority picks D
    d_re = 1'b1; d_addr = 32'h3000;
    step(); mem_ack = 1'b1; #1;
    chk("rr_d_ack", db.ack, 1);
    step(); d_re = 1'b0; mem_ack = 1'b0;
    i_re = 1'b1; d_re = 1'b1; #1;
    chk("rr_idle_between", {gi_b, gd_b}, 0);
    step(); #1;
    chk("rr_tie_grant_b", {gi_b, gd_b}, 2'b10);
    chk("rr_tie_addr_b", mb.addr, 32'h1004);
    chk("prio_tie_grant_a", {gi_a, gd_a}, 2'b01);
    i_re = 1'b0; d_re = 1'b0; #1;
    chk("abort_acks", {ib.ack, da.ack, to_a, to_b}, 0);
    step(); #1;
    chk("abort_idle", {gi_a, gd_a, gi_b, gd_b}, 0);

    // 5: watchdog fires in the 4th owned cycle
    d_re = 1'b1; d_addr = 32'h4000;
    step(); #1;
    chk("wd_c1", {da.ack, to_a, ma.re}, 3'b001);
    step(); step(); #1;
    chk("wd_c3", {da.ack, to_a, ma.re}, 3'b001);
    step(); #1;
    chk("wd_fire", {da.ack, to_a, ma.re}, 3'b110);
    chk("wd_fire_grant", {gi_a, gd_a}, 2'b01);
    step(); d_re = 1'b0; #1;
    chk("wd_idle", {gi_a, gd_a, to_a}, 0);

    // 6: abort, stray ack, reset mid-op
    i_re = 1'b1; i_addr = 32'h5000;
    step(); #1;
    chk("ab_grant", {gi_a, gd_a}, 2'b10);
    i_re = 1'b0; #1;
    chk("ab_drop", {ia.ack, ma.re, to_a}, 0);
    step(); #1;
    chk("ab_idle", {gi_a, gd_a}, 0);
    mem_ack = 1'b1; #1;
    chk("stray_ack", {ia.ack, da.ack}, 0);
    mem_ack = 1'b0;
    i_re = 1'b1;
    step(); #1;
    chk("rst_mid_grant", {gi_a, gd_a}, 2'b10);
    rst = 1'b1; mem_ack = 1'b1; #1;
    chk("rst_mid_no_ack", {ia.ack, ma.re}, 0);
    step(); #1;
    chk("rst_mid_idle", {gi_a, gd_a, ia.ack}, 0);
    rst = 1'b0; mem_ack = 1'b0; i_re = 1'b0;
    step(); #1;
    chk("rst_mid_after", {gi_a, gd_a, ia.ack}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
